// File: rtl/spi_sclk_engine.sv
// spi_sclk_engine: SPI master serial-clock engine.
//   Generates SCLK for one frame of frame_len+1 bits at a half-period of
//   H = (sppr+1) << spr PCLK cycles. The frame starts on an accepted start
//   request and ends with a done pulse, or with an abort pulse if enable
//   drops. Single-cycle sample/shift strobes coincide with the SCLK edge
//   that they belong to, for all four CPOL/CPHA modes.
// Ports:
//   PCLK, PRESETn          clock, asynchronous active-low reset
//   enable                 SPI enabled; low aborts a running frame
//   sppr, spr              prescaler and rate exponent
//   cpol, cpha             SCLK idle level and clock phase
//   frame_len              bits per frame minus 1
//   start                  frame request, level sampled while idle
//   sclk                   serial clock
//   sample_pulse           capture MISO in this cycle
//   shift_pulse            drive the next MOSI bit in this cycle
//   busy, done, abort      frame status; done and abort are 1-cycle pulses
//   half_period            live H for status readback
module spi_sclk_engine #(
  parameter int SPPR_W = 3,
  parameter int SPR_W  = 3,
  parameter int CNT_W  = 12,
  parameter int LEN_W  = 5
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              enable,
  input  logic [SPPR_W-1:0] sppr,
  input  logic [SPR_W-1:0]  spr,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic              start,
  output logic              sclk,
  output logic              sample_pulse,
  output logic              shift_pulse,
  output logic              busy,
  output logic              done,
  output logic              abort,
  output logic [CNT_W-1:0]  half_period
);

  // Edges completed so far, 0..2N-1, with N up to 2^LEN_W.
  localparam int EDGE_W = LEN_W + 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]  h_q, h_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [EDGE_W-1:0] edge_q, edge_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              cpol_q, cpol_d;
  logic              cpha_q, cpha_d;
  logic              sclk_q, sclk_d;
  logic              sample_q, sample_d;
  logic              shift_q, shift_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              abort_q, abort_d;

  logic              start_ok_s;
  logic              terminal_s;
  logic              last_edge_s;
  logic              leading_s;

  // Zero-extend before adding and shifting so that H is never truncated.
  assign half_period = (CNT_W'(sppr) + CNT_W'(1)) << spr;

  assign start_ok_s  = start & enable;
  assign terminal_s  = (cnt_q == (h_q - CNT_W'(1)));
  // The final edge is 2N = 2*(len+1), reached when edge_q = 2*len+1.
  assign last_edge_s = (edge_q == {len_q, 1'b1});
  // The edge about to happen is edge_q+1; it is leading when that is odd.
  assign leading_s   = ~edge_q[0];

  // State register.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_ok_s) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // The terminal edge is checked first so that it wins over a
        // simultaneous disable.
        if (terminal_s && last_edge_s) begin
          state_d = IDLE;
        end else if (!enable) begin
          state_d = IDLE;
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next-values.
  always_comb begin
    h_d      = h_q;
    len_d    = len_q;
    cpol_d   = cpol_q;
    cpha_d   = cpha_q;
    cnt_d    = cnt_q;
    edge_d   = edge_q;
    sclk_d   = sclk_q;
    sample_d = 1'b0;
    shift_d  = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    abort_d  = 1'b0;
    case (state_q)
      IDLE: begin
        sclk_d = cpol;
        cnt_d  = '0;
        edge_d = '0;
        if (start_ok_s) begin
          h_d    = half_period;
          len_d  = frame_len;
          cpol_d = cpol;
          cpha_d = cpha;
          busy_d = 1'b1;
        end else begin
          busy_d = 1'b0;
        end
      end
      RUN: begin
        if (terminal_s) begin
          if (cpha_q) begin
            shift_d  = leading_s;
            sample_d = ~leading_s;
          end else begin
            sample_d = leading_s;
            shift_d  = ~leading_s & ~last_edge_s;
          end
        end else begin
          sample_d = 1'b0;
          shift_d  = 1'b0;
        end

        if (terminal_s && last_edge_s) begin
          sclk_d = ~sclk_q;
          cnt_d  = '0;
          edge_d = '0;
          done_d = 1'b1;
        end else if (!enable) begin
          sclk_d   = cpol_q;
          cnt_d    = '0;
          edge_d   = '0;
          sample_d = 1'b0;
          shift_d  = 1'b0;
          abort_d  = 1'b1;
        end else if (terminal_s) begin
          sclk_d = ~sclk_q;
          cnt_d  = '0;
          edge_d = edge_q + EDGE_W'(1);
          busy_d = 1'b1;
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          busy_d = 1'b1;
        end
      end
      default: begin
        sclk_d = cpol;
        cnt_d  = '0;
        edge_d = '0;
      end
    endcase
  end

  // Datapath and output registers; sclk resets to the live idle level.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      h_q      <= '0;
      len_q    <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      cnt_q    <= '0;
      edge_q   <= '0;
      sclk_q   <= cpol;
      sample_q <= 1'b0;
      shift_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      h_q      <= h_d;
      len_q    <= len_d;
      cpol_q   <= cpol_d;
      cpha_q   <= cpha_d;
      cnt_q    <= cnt_d;
      edge_q   <= edge_d;
      sclk_q   <= sclk_d;
      sample_q <= sample_d;
      shift_q  <= shift_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      abort_q  <= abort_d;
    end
  end

  assign sclk         = sclk_q;
  assign sample_pulse = sample_q;
  assign shift_pulse  = shift_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign abort        = abort_q;

endmodule

// File: tb/tb_spi_sclk_engine.sv
// tb_spi_sclk_engine: directed and randomized checks of spi_sclk_engine
// against a cycle-indexed reference model. Inputs change on the falling
// edge and outputs are sampled there, away from the active rising edge.
module tb_spi_sclk_engine;

  localparam int SPPR_W = 3;
  localparam int SPR_W  = 3;
  localparam int CNT_W  = 12;
  localparam int LEN_W  = 5;

  logic              PCLK = 1'b0;
  logic              PRESETn;
  logic              enable;
  logic [SPPR_W-1:0] sppr;
  logic [SPR_W-1:0]  spr;
  logic              cpol;
  logic              cpha;
  logic [LEN_W-1:0]  frame_len;
  logic              start;
  logic              sclk;
  logic              sample_pulse;
  logic              shift_pulse;
  logic              busy;
  logic              done;
  logic              abort;
  logic [CNT_W-1:0]  half_period;

  int n_chk  = 0;
  int n_fail = 0;

  spi_sclk_engine #(
    .SPPR_W(SPPR_W), .SPR_W(SPR_W), .CNT_W(CNT_W), .LEN_W(LEN_W)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .enable(enable), .sppr(sppr), .spr(spr),
    .cpol(cpol), .cpha(cpha), .frame_len(frame_len), .start(start),
    .sclk(sclk), .sample_pulse(sample_pulse), .shift_pulse(shift_pulse),
    .busy(busy), .done(done), .abort(abort), .half_period(half_period)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_outs(input string tag, input int e_sclk, input int e_busy,
                          input int e_done, input int e_abort, input int e_smp,
                          input int e_shf);
    chk({tag, ".sclk"},   32'(sclk),         e_sclk);
    chk({tag, ".busy"},   32'(busy),         e_busy);
    chk({tag, ".done"},   32'(done),         e_done);
    chk({tag, ".abort"},  32'(abort),        e_abort);
    chk({tag, ".sample"}, 32'(sample_pulse), e_smp);
    chk({tag, ".shift"},  32'(shift_pulse),  e_shf);
  endtask

  // Idle cycles with constant inputs: nothing may start, sclk rests at cpol.
  task automatic idle(input int cycles, input bit st, input bit en);
    for (int c = 0; c < cycles; c++) begin
      start  = st;
      enable = en;
      @(negedge PCLK);
      chk_outs("idle", int'(cpol), 0, 0, 0, 0, 0);
    end
  endtask

  // One frame. Called at a falling edge while the engine is idle; the start
  // applied here is taken at the next rising edge and t0 (k=0) follows.
  // enable is dropped during cycle abort_at (negative: never). With scramble
  // the config and start wiggle randomly during the frame. Returns at the
  // falling edge of the done (or abort) cycle with start still to be set.
  task automatic run_frame(input int f_sppr, input int f_spr, input int f_cpol,
                           input int f_cpha, input int f_len, input int abort_at,
                           input bit scramble);
    int  h, n, last, end_k, e;
    bit  aborted, edge_now, lead;
    int  e_smp, e_shf;
    h = (f_sppr + 1) << f_spr;
    n = f_len + 1;
    last = 2 * n * h;
    aborted = (abort_at >= 0) && (abort_at < last - 1);
    end_k = aborted ? abort_at + 1 : last;
    sppr      = SPPR_W'(f_sppr);
    spr       = SPR_W'(f_spr);
    cpol      = 1'(f_cpol);
    cpha      = 1'(f_cpha);
    frame_len = LEN_W'(f_len);
    start     = 1'b1;
    enable    = 1'b1;
    #1 chk("half_period", 32'(half_period), h);
    for (int k = 0; k <= end_k; k++) begin
      @(negedge PCLK);
      if (aborted && k == end_k) begin
        chk_outs("abort", f_cpol, 0, 0, 1, 0, 0);
      end else begin
        e        = k / h;
        edge_now = (k > 0) && (k % h == 0);
        lead     = (e % 2) == 1;
        if (f_cpha != 0) begin
          e_smp = (edge_now && !lead) ? 1 : 0;
          e_shf = (edge_now && lead) ? 1 : 0;
        end else begin
          e_smp = (edge_now && lead) ? 1 : 0;
          e_shf = (edge_now && !lead && e != 2 * n) ? 1 : 0;
        end
        chk_outs("frame", f_cpol ^ (e % 2), (k < last) ? 1 : 0,
                 (k == last) ? 1 : 0, 0, e_smp, e_shf);
      end
      if (k < end_k) begin
        start = scramble ? 1'($urandom_range(0, 1)) : 1'b0;
        if (scramble) begin
          sppr      = SPPR_W'($urandom_range(0, 7));
          spr       = SPR_W'($urandom_range(0, 7));
          frame_len = LEN_W'($urandom_range(0, 31));
          cpha      = 1'($urandom_range(0, 1));
          cpol      = 1'($urandom_range(0, 1));
        end
        if (k == abort_at) enable = 1'b0;
      end
    end
  endtask

  initial begin
    int r_sppr, r_spr, r_len, r_last, r_abort;
    PRESETn   = 1'b1;
    enable    = 1'b0;
    start     = 1'b0;
    cpol      = 1'b1;
    cpha      = 1'b0;
    sppr      = '0;
    spr       = '0;
    frame_len = '0;

    // Reset values, sclk taken from cpol.
    #2 PRESETn = 1'b0;
    #1 chk_outs("reset", 1, 0, 0, 0, 0, 0);
    @(negedge PCLK);
    @(negedge PCLK);
    PRESETn = 1'b1;
    idle(3, 1'b0, 1'b1);

    // Fastest rate, 8-bit frame.
    cpol = 1'b0;
    idle(2, 1'b0, 1'b1);
    run_frame(0, 0, 0, 0, 7, -1, 1'b0);
    start = 1'b0;
    idle(2, 1'b0, 1'b1);

    // Slowest rate, single bit, mode 3.
    cpol = 1'b1;
    idle(2, 1'b0, 1'b1);
    run_frame(7, 7, 1, 1, 0, -1, 1'b0);
    start = 1'b0;
    idle(2, 1'b0, 1'b1);

    // Mode sweep, H=6, 4 bits; idle level checked before and after.
    for (int m = 0; m < 4; m++) begin
      cpol = 1'(m >> 1);
      idle(2, 1'b0, 1'b1);
      run_frame(2, 1, m >> 1, m & 1, 3, -1, 1'b0);
      start = 1'b0;
      idle(2, 1'b0, 1'b1);
    end

    // Abort at t0+20 with H=4, 16 bits, then a clean full frame.
    cpol = 1'b0;
    run_frame(1, 1, 0, 0, 15, 20, 1'b0);
    start = 1'b0;
    idle(3, 1'b0, 1'b1);
    run_frame(1, 1, 0, 0, 15, -1, 1'b0);
    start = 1'b0;
    idle(2, 1'b0, 1'b1);

    // Final edge coincides with enable falling: done wins.
    run_frame(0, 1, 0, 1, 2, 11, 1'b0);
    start = 1'b0;
    idle(2, 1'b0, 1'b1);

    // Start ignored while disabled.
    idle(4, 1'b1, 1'b0);

    // Config and start wiggling mid-frame.
    run_frame(2, 0, 1, 0, 5, -1, 1'b1);
    start = 1'b0;
    cpol  = 1'b1;
    idle(2, 1'b0, 1'b1);

    // Back-to-back frames with start held high.
    run_frame(0, 1, 1, 0, 1, -1, 1'b0);
    run_frame(1, 0, 1, 1, 2, -1, 1'b0);
    run_frame(0, 0, 1, 0, 0, -1, 1'b0);
    start = 1'b0;
    idle(2, 1'b0, 1'b1);

    // Randomized frames, some aborted, some with mid-frame noise.
    for (int f = 0; f < 12; f++) begin
      r_sppr  = int'($urandom_range(0, 7));
      r_spr   = int'($urandom_range(0, 2));
      r_len   = int'($urandom_range(0, 7));
      r_last  = 2 * (r_len + 1) * ((r_sppr + 1) << r_spr);
      r_abort = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, r_last - 1)) : -1;
      run_frame(r_sppr, r_spr, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                r_len, r_abort, 1'($urandom_range(0, 1)));
      start = 1'b0;
      cpol  = 1'($urandom_range(0, 1));
      idle(2, 1'b0, 1'b1);
    end

    // Asynchronous reset mid-frame, H=2, cpol=0: at k=2 sclk is high.
    cpol      = 1'b0;
    cpha      = 1'b0;
    sppr      = SPPR_W'(1);
    spr       = SPR_W'(0);
    frame_len = LEN_W'(3);
    enable    = 1'b1;
    start     = 1'b1;
    @(negedge PCLK);
    start = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    chk_outs("pre_reset", 1, 1, 0, 0, 1, 0);
    #1 PRESETn = 1'b0;
    #1 chk_outs("async_reset", 0, 0, 0, 0, 0, 0);
    @(negedge PCLK);
    chk_outs("in_reset", 0, 0, 0, 0, 0, 0);
    PRESETn = 1'b1;
    idle(3, 1'b0, 1'b1);
    run_frame(0, 0, 0, 1, 1, -1, 1'b0);
    start = 1'b0;
    idle(2, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
